mult_issue_ctrl: RTL and testbench

- Issue/writeback controller placed directly in front of the Karatsuba/Booth multiplier core.
- Accepts a decoded M-extension multiply op (MUL, MULH, MULHSU, MULHU) from the execute stage over a valid/ready handshake, and latches the operands.
- Drives the core's enable and 12-bit op code, then waits for completion.
- Selects the low or high 32-bit word of the 64-bit product and returns it with a destination register index over a valid/ready handshake.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_word_sel.sv | 12 +
 rtl/mult_issue_ctrl.sv | 97 +++++++++
 tb/tb_mult_issue_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and RV32M multiply op-code constants
package mult_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, CAPTURE, RESP} state_t;
  localparam logic [6:0] OPCODE_OP = 7'b0110011;
  localparam logic [2:0] F3_MUL = 3'b000;
  localparam logic [2:0] F3_MULH = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU = 3'b011;
  localparam logic [11:0] OP_MUL = {2'b01, F3_MUL, OPCODE_OP};
  localparam logic [11:0] OP_MULH = {2'b01, F3_MULH, OPCODE_OP};
  localparam logic [11:0] OP_MULHSU = {2'b01, F3_MULHSU, OPCODE_OP};
  localparam logic [11:0] OP_MULHU = {2'b01, F3_MULHU, OPCODE_OP};
  function automatic logic [11:0] op_code(input logic [2:0] funct3);
    return {2'b01, funct3, OPCODE_OP};
  endfunction
endpackage

// File: rtl/mult_word_sel.sv
// mult_word_sel: picks the low product word for MUL, the high word for MULH/MULHSU/MULHU
module mult_word_sel
  import mult_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        funct3,
  input  logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   word
);
  assign word = funct3 == F3_MUL[1:0] ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
endmodule

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: issue/writeback sequencer in front of the multiplier core.
// Optional watchdog: define MULT_ISSUE_CTRL_TIMEOUT_EN.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic [RD_W-1:0]   req_rd,
  output logic              mul_en,
  output logic [11:0]       mul_op,
  output logic [XLEN-1:0]   mul_rs1,
  output logic [XLEN-1:0]   mul_rs2,
  input  logic              mul_idle,
  input  logic [2*XLEN-1:0] mul_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [RD_W-1:0]   rsp_rd,
  output logic              rsp_err
);
  state_t state, state_n;
  logic [1:0] sel;
  logic [XLEN-1:0] word;
  logic accept, bypass, waiting, timeout;
  assign accept = state == IDLE && req_valid;
  // the core never starts on all-zero operands, so those must skip it entirely
  assign bypass = req_funct3[2] || (req_rs1 == '0 && req_rs2 == '0);
  assign waiting = state == WAIT_BUSY || state == WAIT_DONE;
`ifdef MULT_ISSUE_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  assign timeout = waiting && cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    if (reset || state == LAUNCH) cnt <= '0;
    else if (waiting) cnt <= cnt + 1'b1;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = |TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif
  mult_word_sel #(.XLEN(XLEN)) u_sel (.funct3(sel), .prod(mul_rd), .word(word));
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = req_valid ? (bypass ? RESP : LAUNCH) : IDLE;
      LAUNCH:    state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = mul_idle ? WAIT_BUSY : WAIT_DONE;
      WAIT_DONE: state_n = mul_idle ? CAPTURE : WAIT_DONE;
      CAPTURE:   state_n = RESP;
      RESP:      state_n = rsp_ready ? IDLE : RESP;
      default:   state_n = IDLE;
    endcase
    if (timeout) state_n = RESP;
  end
  always_comb begin
    req_ready = state == IDLE;
    mul_en = state == LAUNCH;
    rsp_valid = state == RESP;
  end
  always_ff @(posedge clk)
    if (reset) begin
      sel <= '0;
      mul_op <= '0;
      mul_rs1 <= '0;
      mul_rs2 <= '0;
      rsp_data <= '0;
      rsp_rd <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        sel <= req_funct3[1:0];
        mul_op <= op_code(req_funct3);
        mul_rs1 <= req_rs1;
        mul_rs2 <= req_rs2;
        rsp_rd <= req_rd;
        rsp_data <= '0;
        rsp_err <= req_funct3[2];
      end
      if (state == CAPTURE) rsp_data <= word;
      if (timeout) begin
        rsp_data <= '0;
        rsp_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb_mult_issue_ctrl: scoreboard bench with a behavioural multiplier core stub
module tb_mult_issue_ctrl;
  typedef struct packed {
    logic [31:0] data;
    logic [4:0] rd;
    logic err;
  } resp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0] req_rd = '0;
  logic mul_en;
  logic [11:0] mul_op;
  logic [31:0] mul_rs1, mul_rs2;
  logic mul_idle;
  logic [63:0] mul_rd;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0] rsp_rd;
  logic rsp_err;
  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt = 0;
  int lat = 3;
  bit stuck = 1'b0;
  int busy;
  logic pend;
  logic [11:0] cop;
  logic [31:0] ca, cb;
  resp_t sb[$];

  mult_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .mul_en(mul_en), .mul_op(mul_op), .mul_rs1(mul_rs1), .mul_rs2(mul_rs2),
    .mul_idle(mul_idle), .mul_rd(mul_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prod(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_, ub;
    sa = $signed({{32{a[31]}}, a});
    sb_ = $signed({{32{b[31]}}, b});
    ub = $signed({32'b0, b});
    case (f3[1:0])
      2'd1: return sa * sb_;
      2'd2: return sa * ub;
      default: return {32'b0, a} * {32'b0, b};
    endcase
  endfunction

  function automatic logic [11:0] exp_op(input logic [2:0] f3);
    case (f3)
      3'd0: return 12'h433;
      3'd1: return 12'h4B3;
      3'd2: return 12'h533;
      3'd3: return 12'h5B3;
      default: return 12'h000;
    endcase
  endfunction

  // core stub: idle drops on enable, rises after lat cycles, product registered one edge later
  always @(posedge clk)
    if (reset) begin
      mul_idle <= 1'b1;
      busy <= 0;
      pend <= 1'b0;
      mul_rd <= '0;
      cop <= '0;
      ca <= '0;
      cb <= '0;
    end else if (mul_en && !stuck && (mul_rs1 != 0 || mul_rs2 != 0)) begin
      busy <= lat;
      mul_idle <= 1'b0;
      cop <= mul_op;
      ca <= mul_rs1;
      cb <= mul_rs2;
    end else if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1) begin
        mul_idle <= 1'b1;
        pend <= 1'b1;
      end
    end else if (pend) begin
      pend <= 1'b0;
      mul_rd <= prod(cop[9:7], ca, cb);
    end

  always @(posedge clk) if (mul_en) en_cnt <= en_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_funct3 = f3;
    req_rs1 = a;
    req_rs2 = b;
    req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] ed, input logic ee, input int stall);
    int n, e0;
    bit bypass;
    logic [31:0] d0;
    resp_t r;
    bypass = f3[2] || (a == 0 && b == 0);
    accept(f3, a, b, rd);
    e0 = en_cnt;
    sb.push_back('{data: ed, rd: rd, err: ee});
    if (!bypass) begin
      check("mul_op", mul_op, exp_op(f3));
      check("mul_rs1", mul_rs1, a);
      check("mul_rs2", mul_rs2, b);
    end
    n = 1;
    while (!rsp_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_valid", rsp_valid, 1);
    if (bypass) check("bypass_latency", n, 1);
    d0 = rsp_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, d0);
      check("stall_req_ready", req_ready, 0);
    end
    r = sb.pop_front();
    check("rsp_data", rsp_data, r.data);
    check("rsp_rd", rsp_rd, r.rd);
    check("rsp_err", rsp_err, r.err);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_req_ready", req_ready, 1);
    check("post_rsp_valid", rsp_valid, 0);
    check("mul_en_cycles", en_cnt - e0, bypass ? 0 : 1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_mul_en"}, mul_en, 0);
    check({tag, "_mul_op"}, mul_op, 0);
    check({tag, "_mul_rs1"}, mul_rs1, 0);
    check({tag, "_mul_rs2"}, mul_rs2, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_rd"}, rsp_rd, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] a, b;
    logic [63:0] p;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_cleared("reset");
    issue(3'd0, 32'd7, 32'd6, 5'd3, 32'd42, 1'b0, 0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE, 1'b0, 0);
    issue(3'd1, 32'h8000_0000, 32'd2, 5'd10, 32'hFFFF_FFFF, 1'b0, 0);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd11, 32'hFFFF_FFFF, 1'b0, 0);
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'd1, 1'b0, 0);
    issue(3'd0, 32'd0, 32'd0, 5'd13, 32'd0, 1'b0, 0);
    issue(3'd0, 32'd7, 32'd6, 5'd14, 32'd42, 1'b0, 5);
    issue(3'd4, 32'd5, 32'd5, 5'd15, 32'd0, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      f3 = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      lat = $urandom_range(1, 6);
      p = prod(f3, a, b);
      issue(f3, a, b, 5'(i + 16), f3 == 3'd0 ? p[31:0] : p[63:32], 1'b0, $urandom_range(0, 2));
    end
    lat = 20;
    accept(3'd0, 32'd3, 32'd4, 5'd7);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("wait_done_idle", mul_idle, 0);
    check("wait_done_rs1", mul_rs1, 32'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_cleared("midop_reset");
    lat = 2;
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd20, 32'hFFFF_FFFF, 1'b0, 0);
`ifdef MULT_ISSUE_CTRL_TIMEOUT_EN
    stuck = 1'b1;
    issue(3'd0, 32'd3, 32'd4, 5'd21, 32'd0, 1'b1, 0);
    stuck = 1'b0;
`endif
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
